// File: rtl/motor_pkg.sv
// Shared types and constants for the BLDC commutation engine: step lookup,
// brake/coast patterns and the dead-time FSM state encoding.
package motor_pkg;

    localparam logic [5:0] BRAKE_LOW = 6'b000111;
    localparam logic [5:0] COAST     = 6'b000000;

    typedef enum logic {
        RUN,
        DEAD
    } dt_state_t;

    // Gate pattern per commutation step: [5:3] high side, [2:0] low side.
    function automatic logic [5:0] step_pattern(input logic [2:0] step);
        case (step)
            3'd0:    return 6'b001010;
            3'd1:    return 6'b100010;
            3'd2:    return 6'b100001;
            3'd3:    return 6'b010001;
            3'd4:    return 6'b010100;
            3'd5:    return 6'b001100;
            default: return COAST;
        endcase
    endfunction

endpackage

// File: rtl/deadtime_inserter.sv
// Delays every switch turn-on until K_DEADTIME quiet cycles have elapsed
// since the last turn-off; turn-offs always pass through immediately.
module deadtime_inserter
    import motor_pkg::*;
#(
    parameter int  K_DEADTIME = 4,
    parameter int  K_WIDTH    = 6,
    localparam int K_DTW      = (K_DEADTIME > 0) ? $clog2(K_DEADTIME + 1) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [K_WIDTH-1:0] i_target,
    output logic [K_WIDTH-1:0] o_pattern,
    output logic               o_dead_active
);

    logic [K_WIDTH-1:0] pattern_q;

    assign o_pattern = pattern_q;

    if (K_DEADTIME == 0) begin : g_no_dead
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) pattern_q <= '0;
            else          pattern_q <= i_target;
        end
        assign o_dead_active = 1'b0;
    end else begin : g_dead
        localparam logic [K_DTW-1:0] RELOAD = K_DTW'(K_DEADTIME - 1);

        dt_state_t          state_q;
        logic [K_DTW-1:0]   cnt_q;
        logic [K_WIDTH-1:0] rising;
        logic [K_WIDTH-1:0] falling;

        assign rising  = i_target & ~pattern_q;
        assign falling = pattern_q & ~i_target;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q   <= RUN;
                cnt_q     <= '0;
                pattern_q <= '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (rising == '0) begin
                            pattern_q <= i_target;
                        end else begin
                            pattern_q <= pattern_q & i_target;
                            cnt_q     <= RELOAD;
                            state_q   <= DEAD;
                        end
                    end
                    DEAD: begin
                        // A fresh turn-off restarts the quiet window.
                        pattern_q <= pattern_q & i_target;
                        if (falling != '0) begin
                            cnt_q <= RELOAD;
                        end else if (cnt_q == '0) begin
                            pattern_q <= i_target;
                            state_q   <= RUN;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end

        assign o_dead_active = (state_q == DEAD);
    end

endmodule

// File: rtl/commutation_engine.sv
// 3-phase BLDC commutation generator: 6-step x N-substep sequencer,
// substep-based power chopping, brake/coast override and dead-time insertion.
module commutation_engine
    import motor_pkg::*;
#(
    parameter int  K_NSUBSTEPS = 10,
    parameter int  K_DEADTIME  = 4,
    localparam int K_SW        = $clog2(K_NSUBSTEPS + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_step_trigger,
    input  logic            i_dir,
    input  logic            i_force_trigger,
    input  logic [2:0]      i_force_step,
    input  logic [K_SW-1:0] i_force_substep,
    input  logic            i_brake,
    input  logic            i_brake_mode,
    input  logic            i_bypass_power,
    input  logic            i_cmd_on_lsb,
    input  logic [K_SW-1:0] i_power,
    output logic [5:0]      o_pattern,
    output logic [2:0]      o_step,
    output logic [K_SW-1:0] o_substep,
    output logic            o_step_pulse,
    output logic            o_dead_active
);

    localparam logic [K_SW-1:0] LAST_SUB = K_SW'(K_NSUBSTEPS - 1);

    logic [2:0]      step_q, step_d;
    logic [K_SW-1:0] substep_q, substep_d;
    logic            pulse_q, pulse_d;
    logic [K_SW-1:0] cmp;
    logic            gate;
    logic [5:0]      mask;
    logic [5:0]      target;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        step_d    = step_q;
        substep_d = substep_q;
        pulse_d   = 1'b0;
        if (i_force_trigger) begin
            step_d    = (i_force_step > 3'd5) ? 3'd0 : i_force_step;
            substep_d = (i_force_substep > LAST_SUB) ? LAST_SUB : i_force_substep;
        end else if (i_enable && i_step_trigger) begin
            if (!i_dir) begin
                if (substep_q == LAST_SUB) begin
                    substep_d = '0;
                    step_d    = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
                    pulse_d   = 1'b1;
                end else begin
                    substep_d = substep_q + 1'b1;
                end
            end else begin
                if (substep_q == '0) begin
                    substep_d = LAST_SUB;
                    step_d    = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
                    pulse_d   = 1'b1;
                end else begin
                    substep_d = substep_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q    <= '0;
            substep_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            step_q    <= step_d;
            substep_q <= substep_d;
            pulse_q   <= pulse_d;
        end
    end

    // Chopping low side counts the substep down so the on-window sits at the step's end.
    assign cmp    = i_cmd_on_lsb ? (LAST_SUB - substep_q) : substep_q;
    assign gate   = i_bypass_power | (i_power > cmp);
    assign mask   = i_cmd_on_lsb ? {3'b111, {3{gate}}} : {{3{gate}}, 3'b111};
    assign target = !i_enable ? COAST
                  : i_brake   ? (i_brake_mode ? COAST : BRAKE_LOW)
                  : step_pattern(step_q) & mask;

    deadtime_inserter #(
        .K_DEADTIME (K_DEADTIME),
        .K_WIDTH    (6)
    ) u_deadtime (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_target      (target),
        .o_pattern     (o_pattern),
        .o_dead_active (o_dead_active)
    );

    assign o_step       = step_q;
    assign o_substep    = substep_q;
    assign o_step_pulse = pulse_q;

endmodule

// File: tb/tb_commutation_engine.sv
// Directed bench for commutation_engine (N=10, DT=4) with an expected-value
// queue filled before each stimulus step and drained at each sample point.
module tb_commutation_engine;

    localparam int N  = 10;
    localparam int DT = 4;
    localparam int SW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, step_trigger, dir, force_trigger;
    logic [2:0]    force_step;
    logic [SW-1:0] force_substep;
    logic          brake, brake_mode, bypass_power, cmd_on_lsb;
    logic [SW-1:0] power;
    logic [5:0]    pattern;
    logic [2:0]    step;
    logic [SW-1:0] substep;
    logic          step_pulse, dead_active;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    commutation_engine #(
        .K_NSUBSTEPS (N),
        .K_DEADTIME  (DT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_step_trigger  (step_trigger),
        .i_dir           (dir),
        .i_force_trigger (force_trigger),
        .i_force_step    (force_step),
        .i_force_substep (force_substep),
        .i_brake         (brake),
        .i_brake_mode    (brake_mode),
        .i_bypass_power  (bypass_power),
        .i_cmd_on_lsb    (cmd_on_lsb),
        .i_power         (power),
        .o_pattern       (pattern),
        .o_step          (step),
        .o_substep       (substep),
        .o_step_pulse    (step_pulse),
        .o_dead_active   (dead_active)
    );

    task automatic expect_val(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [15:0] obs);
        string       tag;
        logic [15:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=%0h expected=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic expect_state(input string tag, input int s, input int sub, input int p);
        expect_val({tag, "_step"}, 16'(s));
        expect_val({tag, "_substep"}, 16'(sub));
        expect_val({tag, "_pulse"}, 16'(p));
    endtask

    task automatic check_state();
        check(16'(step));
        check(16'(substep));
        check(16'(step_pulse));
    endtask

    task automatic expect_pat(input string tag, input logic [5:0] p, input logic d);
        expect_val({tag, "_pattern"}, 16'(p));
        expect_val({tag, "_dead"}, 16'(d));
    endtask

    task automatic check_pat();
        check(16'(pattern));
        check(16'(dead_active));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic force_to(input int s, input int sub);
        force_step    = 3'(s);
        force_substep = SW'(sub);
        force_trigger = 1'b1;
        tick();
        force_trigger = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; step_trigger = 1'b0; dir = 1'b0; force_trigger = 1'b0;
        force_step = '0; force_substep = '0; brake = 1'b0; brake_mode = 1'b0;
        bypass_power = 1'b0; cmd_on_lsb = 1'b0; power = '0;

        // Reset state
        expect_state("reset", 0, 0, 0);
        expect_pat("reset", 6'b000000, 1'b0);
        repeat (3) tick();
        check_state();
        check_pat();

        // Forward walk: 60 triggers, one per cycle
        enable = 1'b1;
        power  = SW'(10);
        rst_n  = 1'b1;
        tick();
        step_trigger = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            expect_state($sformatf("walk%0d", i), (i / N) % 6, i % N, (i % N == 0) ? 1 : 0);
            tick();
            if (step_pulse) pulses++;
            check_state();
        end
        step_trigger = 1'b0;
        expect_val("walk_pulse_count", 16'd6);
        check(16'(pulses));
        expect_pat("walk_settle", 6'b001010, 1'b0);
        repeat (10) tick();
        check_pat();

        // Step 0 -> 1 through the dead-time window
        force_to(0, 9);
        expect_state("dt_trig", 1, 0, 1);
        expect_pat("dt_trig", 6'b001010, 1'b0);
        step_trigger = 1'b1;
        tick();
        step_trigger = 1'b0;
        check_state();
        check_pat();
        for (int i = 1; i <= DT; i++) begin
            expect_pat($sformatf("dt_window%0d", i), 6'b000010, 1'b1);
            tick();
            check_pat();
        end
        expect_pat("dt_on", 6'b100010, 1'b0);
        tick();
        check_pat();

        // Force then reverse trigger across the step boundary
        expect_state("force3", 3, 0, 0);
        force_to(3, 0);
        check_state();
        expect_state("rev", 2, 9, 1);
        dir = 1'b1;
        step_trigger = 1'b1;
        tick();
        step_trigger = 1'b0;
        dir = 1'b0;
        check_state();
        expect_state("rev_hold", 2, 9, 0);
        tick();
        check_state();

        // Out-of-range force with enable low; trigger ignored while disabled
        enable = 1'b0;
        expect_state("force_clamp", 0, 9, 0);
        force_to(7, 12);
        check_state();
        expect_state("trig_disabled", 0, 9, 0);
        step_trigger = 1'b1;
        tick();
        step_trigger = 1'b0;
        check_state();
        expect_pat("disabled", 6'b000000, 1'b0);
        repeat (8) tick();
        check_pat();

        // High-side chopping, power=3, full substep sweep
        enable = 1'b1;
        power  = SW'(3);
        for (int s = 0; s < N; s++) begin
            expect_pat($sformatf("chop_hs_sub%0d", s), (s < 3) ? 6'b001010 : 6'b000010, 1'b0);
            force_to(0, s);
            repeat (8) tick();
            check_pat();
        end
        power = '0;
        expect_pat("chop_hs_p0", 6'b000010, 1'b0);
        force_to(0, 0);
        repeat (8) tick();
        check_pat();

        // Low-side chopping: on-window is the last 3 substeps
        cmd_on_lsb = 1'b1;
        power = SW'(3);
        expect_pat("chop_ls_sub6", 6'b001000, 1'b0);
        force_to(0, 6);
        repeat (8) tick();
        check_pat();
        expect_pat("chop_ls_sub7", 6'b001010, 1'b0);
        force_to(0, 7);
        repeat (8) tick();
        check_pat();

        // Bypass overrides a zero power command
        cmd_on_lsb = 1'b0;
        power = '0;
        bypass_power = 1'b1;
        expect_pat("bypass", 6'b001010, 1'b0);
        force_to(0, 5);
        repeat (8) tick();
        check_pat();
        bypass_power = 1'b0;
        power = SW'(10);

        // Low-side brake requested mid dead-time waits out the full window
        force_to(1, 0);
        expect_pat("brake_enter", 6'b000010, 1'b1);
        tick();
        check_pat();
        brake = 1'b1;
        brake_mode = 1'b0;
        for (int i = 2; i <= DT; i++) begin
            expect_pat($sformatf("brake_wait%0d", i), 6'b000010, 1'b1);
            tick();
            check_pat();
        end
        expect_pat("brake_low", 6'b000111, 1'b0);
        tick();
        check_pat();
        brake_mode = 1'b1;
        expect_pat("brake_coast", 6'b000000, 1'b0);
        tick();
        check_pat();
        brake = 1'b0;
        brake_mode = 1'b0;

        // Asynchronous reset in the middle of a dead-time window
        expect_pat("pre_reset_dead", 6'b000000, 1'b1);
        tick();
        check_pat();
        #2 rst_n = 1'b0;
        #1;
        expect_state("mid_reset", 0, 0, 0);
        expect_pat("mid_reset", 6'b000000, 1'b0);
        check_state();
        check_pat();
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
